// File: rtl/pfiform_pkg.sv
// Shared types and constants for the PFIFORM join-side logic.
package pfiform_pkg;

   localparam int unsigned ELEM_W   = 6;
   localparam int unsigned LANES    = 16;
   localparam int unsigned DATA_W   = ELEM_W * LANES;
   localparam int unsigned AMOUNT_W = 4;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   // Beat amount is encoded as elements-1; widen by one bit so 15 -> 16 fits.
   function automatic logic [AMOUNT_W:0] amount_to_count(input logic [AMOUNT_W-1:0] amount);
      return {1'b0, amount} + (AMOUNT_W+1)'(1);
   endfunction

endpackage

// File: rtl/pfiform_join_arb_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that did
// not own the previous burst wins.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_owner_i,
   output logic       owner_o,
   output logic       found_o
);

   // Pick the single valid requester, or alternate on a tie.
   always_comb begin
      found_o = |valid_i;
      owner_o = 1'b0;
      unique case (valid_i)
         2'b01:   owner_o = 1'b0;
         2'b10:   owner_o = 1'b1;
         2'b11:   owner_o = ~last_owner_i;
         default: owner_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pfiform_join_arb.sv
// Two-requester burst arbiter feeding the PFIFORM join (write) port.
// One owner per burst, round-robin on ties, bursts capped at MAX_BURST beats,
// one idle bubble between bursts, running tally of joined elements.
module pfiform_join_arb
   import pfiform_pkg::*;
#(
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                i_core_clk,
   input  logic                i_rx_rst,
   input  logic                i_req0_valid,
   input  logic                i_req0_last,
   input  logic [AMOUNT_W-1:0] i_req0_amount,
   input  logic [DATA_W-1:0]   i_req0_data,
   output logic                o_req0_ready,
   input  logic                i_req1_valid,
   input  logic                i_req1_last,
   input  logic [AMOUNT_W-1:0] i_req1_amount,
   input  logic [DATA_W-1:0]   i_req1_data,
   output logic                o_req1_ready,
   output logic                o_join_enable,
   input  logic                i_join_permit,
   output logic [AMOUNT_W-1:0] o_join_amount,
   output logic [DATA_W-1:0]   o_join_data,
   output logic [1:0]          o_grant,
   output logic                o_burst_trunc,
   output logic [CNT_W-1:0]    o_elem_count
);

   // Beat index at which the cap forces a release (this is beat MAX_BURST).
   localparam logic [7:0] CapBeat = 8'(MAX_BURST - 1);

   state_t           state_q;
   logic             owner_q;
   logic             last_owner_q;
   logic [7:0]       beat_cnt_q;
   logic [1:0]       grant_q;
   logic             trunc_q;
   logic [CNT_W-1:0] elem_cnt_q;

   logic                pick_owner;
   logic                pick_found;
   logic                in_burst;
   logic                own_valid;
   logic                own_last;
   logic [AMOUNT_W-1:0] own_amount;
   logic [DATA_W-1:0]   own_data;
   logic                xfer;
   logic                cap_hit;

   rr_arb2 u_rr_arb2 (
      .valid_i      ({i_req1_valid, i_req0_valid}),
      .last_owner_i (last_owner_q),
      .owner_o      (pick_owner),
      .found_o      (pick_found)
   );

   // Owner-side mux; data and amount are forced to zero outside a burst.
   always_comb begin
      in_burst   = (state_q == BURST);
      own_valid  = in_burst & (owner_q ? i_req1_valid : i_req0_valid);
      own_last   = owner_q ? i_req1_last : i_req0_last;
      own_amount = '0;
      own_data   = '0;
      if (in_burst) begin
         own_amount = owner_q ? i_req1_amount : i_req0_amount;
         own_data   = owner_q ? i_req1_data : i_req0_data;
      end
      xfer    = own_valid & i_join_permit;
      cap_hit = (beat_cnt_q == CapBeat);
   end

   // Join-side and requester handshake outputs.
   always_comb begin
      o_join_enable = own_valid;
      o_join_amount = own_amount;
      o_join_data   = own_data;
      o_req0_ready  = xfer & ~owner_q;
      o_req1_ready  = xfer & owner_q;
      o_grant       = grant_q;
      o_burst_trunc = trunc_q;
      o_elem_count  = elem_cnt_q;
   end

   // Burst FSM with registered grant, truncation pulse and element tally.
   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         beat_cnt_q   <= '0;
         grant_q      <= 2'b00;
         trunc_q      <= 1'b0;
         elem_cnt_q   <= '0;
      end else begin
         trunc_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q    <= BURST;
                  owner_q    <= pick_owner;
                  grant_q    <= pick_owner ? 2'b10 : 2'b01;
                  beat_cnt_q <= '0;
               end
            end
            BURST: begin
               if (xfer) begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  elem_cnt_q <= elem_cnt_q + CNT_W'(amount_to_count(own_amount));
                  if (own_last || cap_hit) begin
                     state_q      <= IDLE;
                     last_owner_q <= owner_q;
                     grant_q      <= 2'b00;
                     beat_cnt_q   <= '0;
                     trunc_q      <= ~own_last;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
